// File: rtl/gen_mux_pkg.sv
// ----------------------------------------------------------------------------
// gen_mux_pkg
// Shared constants for the generate_set_of_mux word-select primitive.
//   GEN_MUX_DEFAULT_WIDTH : default bus width (bits per bus / mux2 cells)
//   GEN_MUX_MAX_WIDTH     : largest supported bus width
// ----------------------------------------------------------------------------
package gen_mux_pkg;

    localparam int GEN_MUX_DEFAULT_WIDTH = 4;
    localparam int GEN_MUX_MAX_WIDTH     = 64;

endpackage : gen_mux_pkg

// File: rtl/mux2_cell.sv
// ----------------------------------------------------------------------------
// mux2_cell
// Single-bit 2:1 multiplexer, the leaf cell of generate_set_of_mux.
// Ports:
//   a   in  1  data selected when sel = 0
//   b   in  1  data selected when sel = 1
//   sel in  1  select
//   f   out 1  sel ? b : a
// ----------------------------------------------------------------------------
module mux2_cell (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic f
);

    assign f = sel ? b : a;

endmodule : mux2_cell

// File: rtl/generate_set_of_mux.sv
// ----------------------------------------------------------------------------
// generate_set_of_mux
// Bank of WIDTH 2:1 muxes sharing one select, with a combinational result f
// and a registered copy f_q qualified by out_valid. Buses are MSB-first
// ([0:WIDTH-1], bit 0 is the MSB); a[i]/b[i] always drive f[i].
//
// Optional build macro:
//   GEN_SET_OF_MUX_PARITY_EN  adds output parity_q = XOR-reduce of f_q,
//                             registered alongside f_q.
//
// Parameters:
//   WIDTH      bits per bus, 1 .. GEN_MUX_MAX_WIDTH
// Ports:
//   clk        in   1        rising-edge clock for the output register
//   rst        in   1        asynchronous, active-high reset
//   a          in   [0:W-1]  data selected when sel = 0
//   b          in   [0:W-1]  data selected when sel = 1
//   sel        in   1        shared select for all bits
//   in_valid   in   1        capture a/b/sel result into f_q
//   f          out  [0:W-1]  combinational mux result
//   f_q        out  [0:W-1]  registered mux result
//   parity_q   out  1        (macro only) parity of f_q
//   out_valid  out  1        f_q was captured on the last edge
// ----------------------------------------------------------------------------
module generate_set_of_mux
    import gen_mux_pkg::*;
#(
    parameter int WIDTH = GEN_MUX_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             sel,
    input  logic             in_valid,
    output logic [0:WIDTH-1] f,
    output logic [0:WIDTH-1] f_q,
`ifdef GEN_SET_OF_MUX_PARITY_EN
    output logic             parity_q,
`endif
    output logic             out_valid
);

    // Reject out-of-range widths at elaboration rather than building a
    // degenerate or oversized bank.
    if (WIDTH < 1 || WIDTH > GEN_MUX_MAX_WIDTH) begin : gen_width_check
        $error("generate_set_of_mux: WIDTH out of range");
    end

    // One mux2 cell per bit; the shared select fans out to every cell.
    for (genvar i = 0; i < WIDTH; i++) begin : gen_mux
        mux2_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .sel (sel),
            .f   (f[i])
        );
    end

    // Output register: f_q holds its value when in_valid is low, while
    // out_valid simply mirrors the previous cycle's in_valid.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values; blocking would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                f_q <= f;
            end
        end
    end

`ifdef GEN_SET_OF_MUX_PARITY_EN
    // Parity is computed from f so it lands in the same edge as f_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (in_valid) begin
            parity_q <= ^f;
        end
    end
`else
    // Parity output and register are not built in this configuration.
`endif

endmodule : generate_set_of_mux

// File: tb/tb_generate_set_of_mux.sv
// ----------------------------------------------------------------------------
// tb_generate_set_of_mux
// Scoreboard bench for generate_set_of_mux. A driver applies one stimulus per
// cycle on the falling edge and pushes the register contents expected after
// the next rising edge; a monitor pops and compares just after each rising
// edge. The combinational output f is checked directly after each drive.
// ----------------------------------------------------------------------------
module tb_generate_set_of_mux;

    parameter int W = 4;

    typedef struct {
        logic [0:W-1] fq;
        logic         ov;
        logic         par;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:W-1] a;
    logic [0:W-1] b;
    logic         sel;
    logic         in_valid;
    logic [0:W-1] f;
    logic [0:W-1] f_q;
    logic         out_valid;
`ifdef GEN_SET_OF_MUX_PARITY_EN
    logic         parity_q;
`endif

    int vectors     = 0;
    int miscompares = 0;

    exp_t sb[$];

    // Reference register state, updated by the driver.
    logic [0:W-1] m_fq;
    logic         m_ov;
    logic         m_par;

    // MSB-first 64-bit patterns; the leftmost W bits are used.
    logic [0:63] pat_a  = 64'hA000_0000_0000_0000;  // 1010...
    logic [0:63] pat_b  = 64'hB000_0000_0000_0000;  // 1011...
    logic [0:63] pat_b0 = 64'h8000_0000_0000_0000;  // 1000...
    logic [0:63] pat_z  = 64'h0;
    logic [0:63] pat_ff = 64'hFFFF_FFFF_FFFF_FFFF;

    generate_set_of_mux #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .in_valid  (in_valid),
        .f         (f),
        .f_q       (f_q),
`ifdef GEN_SET_OF_MUX_PARITY_EN
        .parity_q  (parity_q),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural mux: take every bit from b when sel is 1, else from a.
    function automatic logic [0:W-1] model_mux(input logic [0:W-1] ma,
                                               input logic [0:W-1] mb,
                                               input logic         msel);
        return msel ? mb : ma;
    endfunction

    // Drive one cycle of stimulus, check f, and queue the register
    // expectations for the coming rising edge.
    task automatic drive(input logic v, input logic s,
                         input logic [0:W-1] da, input logic [0:W-1] db);
        exp_t e;
        logic [0:W-1] mf;
        @(negedge clk);
        in_valid = v;
        sel      = s;
        a        = da;
        b        = db;
        mf = model_mux(da, db, s);
        if (v) begin
            m_fq  = mf;
            m_par = ($countones(mf) % 2) == 1;
        end
        m_ov = v;
        e.fq  = m_fq;
        e.ov  = m_ov;
        e.par = m_par;
        sb.push_back(e);
        #1;
        check("f_comb", 64'(f), 64'(mf));
    endtask

    // Monitor: compare the register outputs after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("f_q", 64'(f_q), 64'(e.fq));
                check("out_valid", 64'(out_valid), 64'(e.ov));
`ifdef GEN_SET_OF_MUX_PARITY_EN
                check("parity_q", 64'(parity_q), 64'(e.par));
`endif
            end
        end
    end

    initial begin
        logic [0:W-1] va, vb, v1, vz;
        int budget;
        va = pat_a[0:W-1];
        vb = pat_b[0:W-1];
        v1 = pat_b0[0:W-1];
        vz = pat_z[0:W-1];
        m_fq  = '0;
        m_ov  = 1'b0;
        m_par = 1'b0;

        // Reset held: f is live, registers are cleared.
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = va;
        b        = vb;
        sel      = 1'b0;
        #2;
        check("rst_f_sel0", 64'(f), 64'(va));
        check("rst_f_q", 64'(f_q), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        sel = 1'b1;
        #1;
        check("rst_f_sel1", 64'(f), 64'(vb));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_f_q", 64'(f_q), 64'(0));
        check("rst_hold_out_valid", 64'(out_valid), 64'(0));
`ifdef GEN_SET_OF_MUX_PARITY_EN
        check("rst_parity_q", 64'(parity_q), 64'(0));
`endif
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;

        // Capture, then hold with in_valid low.
        drive(1'b1, 1'b1, va, vb);
        drive(1'b0, 1'b1, va, vb);
        // Bit order: only the MSB (bit 0) of a is set.
        drive(1'b0, 1'b0, v1, vz);
        check("bit0_set", 64'(f[0]), 64'(1));
        // Parity of 1010... (even number of ones for any W>=1 prefix? no:
        // the model computes it), captured via sel=0.
        drive(1'b1, 1'b0, va, vb);
        drive(1'b1, 1'b1, va, vb);

        // Asynchronous reset between edges while f_q holds a value.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_f_q", 64'(f_q), 64'(0));
        check("async_rst_out_valid", 64'(out_valid), 64'(0));
`ifdef GEN_SET_OF_MUX_PARITY_EN
        check("async_rst_parity_q", 64'(parity_q), 64'(0));
`endif
        a   = pat_ff[0:W-1];
        sel = 1'b0;
        #1;
        check("async_rst_f_tracks", 64'(f), 64'(pat_ff[0:W-1]));
        m_fq  = '0;
        m_ov  = 1'b0;
        m_par = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  W'($urandom), W'($urandom));
        end
        drive(1'b0, 1'b0, vz, vz);

        // Drain the scoreboard with a bounded wait.
        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_generate_set_of_mux

// File: doc/generate_set_of_mux.md
Name: generate_set_of_mux

Overview:
- Bank of WIDTH identical 2:1 multiplexers built with a generate loop: one shared select picks vector `a` or vector `b` per bit.
- Provides a combinational result `f` and a registered copy `f_q` with a valid flag.
- Used as the generic word-select primitive wherever a datapath chooses between two equal-width buses.

Parameters:
- WIDTH, 4, number of bits per bus and number of instantiated mux2 cells (legal range 1 to 64).

Ports:
- clk  input  1  rising-edge clock for the output register.
- rst  input  1  asynchronous, active-high reset.
- a  input  [0:WIDTH-1]  data selected when sel=0; bit 0 is the MSB.
- b  input  [0:WIDTH-1]  data selected when sel=1; bit 0 is the MSB.
- sel  input  1  shared select for all bits.
- in_valid  input  1  qualifies a/b/sel for capture into the register.
- f  output  [0:WIDTH-1]  combinational mux result.
- f_q  output  [0:WIDTH-1]  registered mux result.
- out_valid  output  1  f_q holds a captured result.

Behaviour:
- Combinational path, per bit i in 0..WIDTH-1: f[i] = sel ? b[i] : a[i].
  - Zero latency; f does not depend on clk or rst.
  - f updates on any change of a, b or sel.
- Bit order is ascending, [0:WIDTH-1]: a[0] drives f[0]; no bit reversal anywhere.
- Registered path:
  - on posedge clk with in_valid=1: f_q <= f and out_valid <= 1.
  - with in_valid=0: f_q holds its value and out_valid <= 0.
  - Latency is 1 cycle from the in_valid edge to out_valid.
- Reset: while rst=1, immediately (asynchronously) f_q = 0 and out_valid = 0. Reset deasserting mid-stream has no effect on f. The first capture happens on the first posedge with rst=0 and in_valid=1.
- sel=X or sel=Z: f is don't-care (no defined value); any f_q captured from it is also don't-care.
- No handshake back-pressure exists: every valid input is captured.
- No internal state besides f_q and out_valid.

Optional Feature:
- Macro GEN_SET_OF_MUX_PARITY_EN.
- Defined:
  - extra output port `parity_q` (1 bit) = XOR-reduce of f_q, registered in the same cycle as f_q.
  - reset value 0; it holds whenever f_q holds.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package gen_mux_pkg holds:
  - constant GEN_MUX_DEFAULT_WIDTH = 4;
  - constant GEN_MUX_MAX_WIDTH = 64.
- Natural sub-module mux2_cell: 1-bit inputs a, b, sel and output f, with f = sel ? b : a.
  - Instantiated WIDTH times inside a named generate loop (gen_mux[i]).
  - The top level adds the register stage and the optional parity.

Test Plan:
- rst=1, then a=4'b1010, b=4'b1011, sel=0 -> f=4'b1010 immediately; f_q=0 and out_valid=0 while rst is held.
- Same a/b, switch sel 0->1 -> f changes to 4'b1011 in the same timestep with no clock edge.
- rst=0, in_valid=1, sel=1, a=4'b1010, b=4'b1011, one posedge -> f_q=4'b1011 and out_valid=1; next edge with in_valid=0 -> f_q holds 4'b1011 and out_valid=0.
- Bit ordering with a=4'b1000 (only bit 0 set), b=4'b0000, sel=0 -> f[0]=1 and f[1:3]=0.
- Assert rst asynchronously between clock edges while f_q=4'b1011 -> f_q=0 and out_valid=0 before the next edge; f still tracks its inputs.
- With GEN_SET_OF_MUX_PARITY_EN defined, capture 4'b1011 -> parity_q=1; capture 4'b1010 -> parity_q=0. Repeat the previous scenarios with WIDTH=1 and WIDTH=8.
